mod_n_down_counter: RTL and testbench

- Synchronous modulo-N down counter. It is the count-down companion to the team's mod-7 up counter.
- Counts MOD-1, MOD-2, ..., 0, then wraps back to MOD-1.
- Supports count enable, parallel load, and a borrow output for cascading stages (e.g. building timers from chained down counters).
- Fully synchronous: no ripple clocking, no derived clocks.

---
 rtl/mod_n_down_counter_if.sv | 25 ++
 rtl/mod_n_down_counter.sv | 37 +++
 tb/tb_mod_n_down_counter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_down_counter_if.sv
// Bus bundle for mod_n_down_counter: control/load inputs toward the counter,
// count, terminal-count and borrow back from it.
interface mod_n_down_counter_if #(
  parameter int W = 3
);
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] y;
  logic         tc;
  logic         borrow;

  // Control inputs carry no valid/ready handshake: en and load are sampled
  // on every rising clk edge, and y/tc/borrow are valid continuously after
  // the first reset.
  modport master (
    output en, load, load_val,
    input  y, tc, borrow
  );

  modport slave (
    input  en, load, load_val,
    output y, tc, borrow
  );
endinterface

// File: rtl/mod_n_down_counter.sv
// Synchronous modulo-MOD down counter with enable, clamped parallel load
// and a borrow output meant to drive the enable of a cascaded stage.
module mod_n_down_counter #(
  parameter int MOD = 7,
  parameter int W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  mod_n_down_counter_if.slave   bus
);
  localparam logic [W-1:0] MaxVal = W'(MOD - 1);

  logic [W-1:0] y_d;
  logic [W-1:0] y_q;

  // Loads above MOD-1 clamp so unused codes are never entered.
  always_comb begin
    y_d = y_q;
    if (bus.load) begin
      y_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
    end else if (bus.en) begin
      y_d = (y_q == '0) ? MaxVal : (y_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= MaxVal;
    end else begin
      y_q <= y_d;
    end
  end

  assign bus.y      = y_q;
  assign bus.tc     = (y_q == '0);
  assign bus.borrow = bus.en & bus.tc & ~bus.load;
endmodule

// File: tb/tb_mod_n_down_counter.sv
// Bench for mod_n_down_counter: single stages with MOD=7 and MOD=8, plus
// a cascade of MOD=7 low and MOD=3 high stages, checked every cycle
// against an arithmetic model.
module tb_mod_n_down_counter;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  logic en_c  = 1'b0;

  mod_n_down_counter_if #(.W(3)) a_if ();
  mod_n_down_counter_if #(.W(3)) b_if ();
  mod_n_down_counter_if #(.W(3)) lo_if ();
  mod_n_down_counter_if #(.W(2)) hi_if ();

  mod_n_down_counter #(.MOD(7), .W(3)) u_a  (.clk(clk), .reset(rst_a), .bus(a_if.slave));
  mod_n_down_counter #(.MOD(8), .W(3)) u_b  (.clk(clk), .reset(rst_b), .bus(b_if.slave));
  mod_n_down_counter #(.MOD(7), .W(3)) u_lo (.clk(clk), .reset(rst_c), .bus(lo_if.slave));
  mod_n_down_counter #(.MOD(3), .W(2)) u_hi (.clk(clk), .reset(rst_c), .bus(hi_if.slave));

  assign lo_if.en       = en_c;
  assign lo_if.load     = 1'b0;
  assign lo_if.load_val = 3'd0;
  assign hi_if.en       = lo_if.borrow;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = 2'd0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Single stages: next = clamp(load) or (y + MOD - 1) % MOD.
  // Cascade: one mixed-radix number total = hi*7 + lo counting mod 21.
  int  ma = 0, mb = 0, mtot = 0;
  bit  va = 0, vb = 0, vc = 0;

  function automatic int next_val(input int cur, input int m, input bit r,
                                  input bit ld, input int lv, input bit e);
    if (r)  return m - 1;
    if (ld) return (lv >= m) ? m - 1 : lv;
    if (e)  return (cur + m - 1) % m;
    return cur;
  endfunction

  always @(posedge clk) begin
    ma = next_val(ma, 7, rst_a, a_if.load, int'(a_if.load_val), a_if.en);
    mb = next_val(mb, 8, rst_b, b_if.load, int'(b_if.load_val), b_if.en);
    if (rst_a) va = 1;
    if (rst_b) vb = 1;
    if (rst_c) begin
      mtot = 20;
      vc   = 1;
    end else if (en_c) begin
      mtot = (mtot + 20) % 21;
    end
  end

  // Compare process: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (va) begin
      chk("a_y", int'(a_if.y), ma);
      chk("a_tc", int'(a_if.tc), int'(ma == 0));
      chk("a_borrow", int'(a_if.borrow), int'(a_if.en && !a_if.load && ma == 0));
    end
    if (vb) begin
      chk("b_y", int'(b_if.y), mb);
      chk("b_borrow", int'(b_if.borrow), int'(b_if.en && !b_if.load && mb == 0));
    end
    if (vc) begin
      chk("lo_y", int'(lo_if.y), mtot % 7);
      chk("hi_y", int'(hi_if.y), mtot / 7);
      chk("lo_borrow", int'(lo_if.borrow), int'(en_c && (mtot % 7) == 0));
      chk("hi_borrow", int'(hi_if.borrow), int'(en_c && mtot == 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit r, input bit ld, input int lv, input bit e);
    rst_a         = r;
    a_if.load     = ld;
    a_if.load_val = 3'(lv);
    a_if.en       = e;
  endtask

  // ---------------- directed stimulus ----------------
  int seq [17] = '{6, 5, 4, 3, 2, 1, 0, 6, 5, 4, 3, 2, 1, 0, 6, 5, 4};

  initial begin
    drive_a(0, 0, 0, 0);
    b_if.load = 0; b_if.load_val = 0; b_if.en = 0;

    // Reset then free-run 16 cycles
    drive_a(1, 0, 0, 0);
    cyc();
    chk("lit_reset_y", int'(a_if.y), 6);
    chk("lit_reset_tc", int'(a_if.tc), 0);
    chk("lit_reset_borrow", int'(a_if.borrow), 0);
    drive_a(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("lit_run_borrow", int'(a_if.borrow), int'(seq[i] == 0));
      chk("lit_run_tc", int'(a_if.tc), int'(seq[i] == 0));
      cyc();
      chk("lit_run_y", int'(a_if.y), seq[i + 1]);
    end

    // Hold at 3
    cyc();
    chk("lit_pre_hold", int'(a_if.y), 3);
    drive_a(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lit_hold_y", int'(a_if.y), 3);
      chk("lit_hold_borrow", int'(a_if.borrow), 0);
    end

    // Load in range, then clamp
    drive_a(0, 1, 4, 0);
    cyc();
    chk("lit_load4", int'(a_if.y), 4);
    drive_a(0, 1, 7, 0);
    cyc();
    chk("lit_load7_clamp", int'(a_if.y), 6);

    // Modulus-8 stage: 7 is a legal load value
    rst_b = 1;
    cyc();
    chk("lit_b_reset", int'(b_if.y), 7);
    rst_b = 0; b_if.load = 1; b_if.load_val = 3'd2;
    cyc();
    chk("lit_b_load2", int'(b_if.y), 2);
    b_if.load_val = 3'd7;
    cyc();
    chk("lit_b_load7", int'(b_if.y), 7);
    b_if.load = 0; b_if.en = 1;
    cyc();
    chk("lit_b_dec", int'(b_if.y), 6);
    b_if.en = 0;

    // Load beats en at y=0, borrow suppressed
    drive_a(0, 1, 0, 0);
    cyc();
    chk("lit_load0", int'(a_if.y), 0);
    drive_a(0, 1, 2, 1);
    #1;
    chk("lit_load_en_borrow", int'(a_if.borrow), 0);
    chk("lit_load_en_tc", int'(a_if.tc), 1);
    cyc();
    chk("lit_load_en_y", int'(a_if.y), 2);
    // Reset beats en at y=2
    drive_a(1, 0, 0, 1);
    cyc();
    chk("lit_rst_en_y", int'(a_if.y), 6);

    // Reset mid free-run at y=2, en held high
    drive_a(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc();
    chk("lit_mid_pre", int'(a_if.y), 2);
    drive_a(1, 0, 0, 1);
    cyc();
    chk("lit_mid_rst", int'(a_if.y), 6);
    drive_a(0, 0, 0, 1);
    cyc();
    chk("lit_mid_5", int'(a_if.y), 5);
    cyc();
    chk("lit_mid_4", int'(a_if.y), 4);
    drive_a(0, 0, 0, 0);

    // Cascade: modulus-7 low / modulus-3 high
    rst_c = 1; en_c = 0;
    cyc();
    chk("lit_casc_lo_rst", int'(lo_if.y), 6);
    chk("lit_casc_hi_rst", int'(hi_if.y), 2);
    rst_c = 0; en_c = 1;
    for (int i = 1; i <= 21; i++) begin
      cyc();
      if (i == 6)  chk("lit_casc_lo_0", int'(lo_if.y), 0);
      if (i == 7)  chk("lit_casc_hi_1", int'(hi_if.y), 1);
      if (i == 14) chk("lit_casc_hi_0", int'(hi_if.y), 0);
      if (i == 21) begin
        chk("lit_casc_lo_end", int'(lo_if.y), 6);
        chk("lit_casc_hi_end", int'(hi_if.y), 2);
      end
    end
    en_c = 0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
